// File: rtl/rvh_l1d_pkg.sv
// Shared types and defaults for the L1D PLRU replacement control path.
// The hit-update entry widths here define the default cache geometry.
package rvh_l1d_pkg;

    localparam int L1D_ENTRY_IDX   = 6;
    localparam int L1D_WAY_NUM_IDX = 2;
    localparam int L1D_STARVE_LIM  = 4;

    typedef struct packed {
        logic [L1D_ENTRY_IDX-1:0]   set_idx;
        logic [L1D_WAY_NUM_IDX-1:0] way_idx;
    } plru_hit_upd_t;

endpackage

// File: rtl/rvh_l1d_plru_upd_fifo.sv
// Pending PLRU hit-update queue: in-order FIFO of {set, way} entries with an
// occupancy counter; push and pop may coincide, including when full.
module rvh_l1d_plru_upd_fifo
    import rvh_l1d_pkg::*;
#(
    parameter int q_depth = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_push,
    input  logic [$bits(plru_hit_upd_t)-1:0]  i_push_entry,
    input  logic                              i_pop,
    output logic [$bits(plru_hit_upd_t)-1:0]  o_head_entry,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int PTR_W = (q_depth > 1) ? $clog2(q_depth) : 1;
    localparam int CNT_W = $clog2(q_depth) + 1;

    plru_hit_upd_t    r_mem [q_depth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(q_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_head_entry = r_mem[r_rd_ptr];
    assign o_full       = (r_count == CNT_W'(q_depth));
    assign o_empty      = (r_count == '0);

endmodule

// File: rtl/rvh_l1d_plru_ctrl.sv
// L1D PLRU access controller: round-robin hit-update arbitration into a queue,
// refill victim lookup with priority, and a starvation guard for queued hits.
module rvh_l1d_plru_ctrl
    import rvh_l1d_pkg::*;
#(
    parameter int entry_num    = 64,
    parameter int entry_idx    = L1D_ENTRY_IDX,
    parameter int way_num_idx  = L1D_WAY_NUM_IDX,
    parameter int hit_port_num = 2,
    parameter int q_depth      = 4,
    parameter int starve_lim   = L1D_STARVE_LIM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [hit_port_num-1:0]             hit_vld_i,
    input  logic [hit_port_num*entry_idx-1:0]   hit_set_i,
    input  logic [hit_port_num*way_num_idx-1:0] hit_way_i,
    output logic [hit_port_num-1:0]             hit_rdy_o,
    input  logic                                refill_vld_i,
    input  logic [entry_idx-1:0]                refill_set_i,
    output logic                                refill_rdy_o,
    output logic                                refill_resp_vld_o,
    output logic [way_num_idx-1:0]              refill_resp_way_o,
    output logic                                plru_upd_en_hit_o,
    output logic [entry_idx-1:0]                plru_upd_set_idx_hit_o,
    output logic [way_num_idx-1:0]              plru_upd_way_idx_hit_o,
    output logic                                plru_rd_en_refill_o,
    output logic [entry_idx-1:0]                plru_rd_idx_refill_o,
    input  logic [way_num_idx-1:0]              plru_rd_dat_refill_i
);

    localparam int RR_W     = (hit_port_num > 1) ? $clog2(hit_port_num) : 1;
    localparam int STREAK_W = $clog2(starve_lim + 1);

    logic [RR_W-1:0]     r_rr_ptr;
    logic [STREAK_W-1:0] r_streak;
    logic                r_resp_vld;
    logic [way_num_idx-1:0] r_resp_way;

    logic [RR_W-1:0] w_grant_idx;
    logic            w_grant_any;
    logic            w_push;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_refill_hs;
    logic            w_starve;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    plru_hit_upd_t   w_push_entry;
    plru_hit_upd_t   w_head_entry;

    function automatic logic [RR_W-1:0] wrap_port(input int p);
        return (p >= hit_port_num) ? RR_W'(p - hit_port_num) : RR_W'(p);
    endfunction

    // Scan from the far end towards r_rr_ptr so the closest valid port wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = hit_port_num - 1; k >= 0; k--) begin
            if (hit_vld_i[wrap_port(int'(r_rr_ptr) + k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = wrap_port(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_starve     = (r_streak == STREAK_W'(starve_lim));
    assign refill_rdy_o = ~w_starve;
    assign w_refill_hs  = refill_vld_i & refill_rdy_o;
    assign w_pop        = ~w_refill_hs & ~w_fifo_empty;
    assign w_push_ok    = ~w_fifo_full | w_pop;
    assign w_push       = w_grant_any & w_push_ok;

    always_comb begin
        hit_rdy_o = '0;
        if (w_push) hit_rdy_o[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_push_entry         = '0;
        w_push_entry.set_idx = hit_set_i[int'(w_grant_idx)*entry_idx +: entry_idx];
        w_push_entry.way_idx = hit_way_i[int'(w_grant_idx)*way_num_idx +: way_num_idx];
    end

    rvh_l1d_plru_upd_fifo #(
        .q_depth      (q_depth)
    ) u_upd_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head_entry (w_head_entry),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= wrap_port(int'(w_grant_idx) + 1);
        end
    end

    // Streak counts refills that jumped ahead of queued hits; at the limit the
    // refill port is closed for one cycle so the queue head gets through.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_fifo_empty || w_pop) begin
            r_streak <= '0;
        end else if (w_refill_hs) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_vld <= 1'b0;
            r_resp_way <= '0;
        end else begin
            r_resp_vld <= w_refill_hs;
            if (w_refill_hs) r_resp_way <= plru_rd_dat_refill_i;
        end
    end

    // A set index outside the PLRU array indicates a broken requester.
    always_ff @(posedge clk) begin
        if (!rst && refill_vld_i) assert (int'(refill_set_i) < entry_num);
    end

    assign refill_resp_vld_o      = r_resp_vld;
    assign refill_resp_way_o      = r_resp_way;
    assign plru_upd_en_hit_o      = w_pop;
    assign plru_upd_set_idx_hit_o = w_head_entry.set_idx;
    assign plru_upd_way_idx_hit_o = w_head_entry.way_idx;
    assign plru_rd_en_refill_o    = w_refill_hs;
    assign plru_rd_idx_refill_o   = refill_set_i;

endmodule

// File: tb/tb_rvh_l1d_plru_ctrl.sv
// Directed bench for rvh_l1d_plru_ctrl: stimulus pushes expected hit updates and
// refill responses into queues that a negedge monitor pops and compares.
module tb_rvh_l1d_plru_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hit_vld_i;
    logic [11:0] hit_set_i;
    logic [3:0]  hit_way_i;
    logic [1:0]  hit_rdy_o;
    logic        refill_vld_i;
    logic [5:0]  refill_set_i;
    logic        refill_rdy_o;
    logic        refill_resp_vld_o;
    logic [1:0]  refill_resp_way_o;
    logic        plru_upd_en_hit_o;
    logic [5:0]  plru_upd_set_idx_hit_o;
    logic [1:0]  plru_upd_way_idx_hit_o;
    logic        plru_rd_en_refill_o;
    logic [5:0]  plru_rd_idx_refill_o;
    logic [1:0]  plru_rd_dat_refill_i;

    int nCompared;
    int nMismatched;

    logic [7:0] expHit[$];
    logic [1:0] expResp[$];
    logic [7:0] expHitHead;
    logic [1:0] expRespHead;

    localparam logic [1:0] T3_HIT_RDY [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic       T3_REF_RDY [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic       T3_UPD_EN  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic       T4_REF_RDY [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic       T4_UPD_EN  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    rvh_l1d_plru_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .hit_vld_i              (hit_vld_i),
        .hit_set_i              (hit_set_i),
        .hit_way_i              (hit_way_i),
        .hit_rdy_o              (hit_rdy_o),
        .refill_vld_i           (refill_vld_i),
        .refill_set_i           (refill_set_i),
        .refill_rdy_o           (refill_rdy_o),
        .refill_resp_vld_o      (refill_resp_vld_o),
        .refill_resp_way_o      (refill_resp_way_o),
        .plru_upd_en_hit_o      (plru_upd_en_hit_o),
        .plru_upd_set_idx_hit_o (plru_upd_set_idx_hit_o),
        .plru_upd_way_idx_hit_o (plru_upd_way_idx_hit_o),
        .plru_rd_en_refill_o    (plru_rd_en_refill_o),
        .plru_rd_idx_refill_o   (plru_rd_idx_refill_o),
        .plru_rd_dat_refill_i   (plru_rd_dat_refill_i)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] hv, input logic [5:0] s0, input logic [1:0] w0,
                                 input logic [5:0] s1, input logic [1:0] w1,
                                 input logic rv, input logic [5:0] rs, input logic [1:0] rd);
        hit_vld_i            = hv;
        hit_set_i            = {s1, s0};
        hit_way_i            = {w1, w0};
        refill_vld_i         = rv;
        refill_set_i         = rs;
        plru_rd_dat_refill_i = rd;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 1'b0, 6'd0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        idle();
        expHit.delete();
        expResp.delete();
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && (expHit.size() != 0 || expResp.size() != 0); i++) tick();
        checkOutput("drain_pending", 32'(expHit.size() + expResp.size()), 32'd0);
    endtask

    // Monitor: every hit update or refill response the DUT shows must be next in line.
    always @(negedge clk) begin
        if (!rst) begin
            if (plru_upd_en_hit_o || plru_rd_en_refill_o)
                checkOutput("strobe_overlap", 32'(plru_upd_en_hit_o & plru_rd_en_refill_o), 32'd0);
            if (plru_upd_en_hit_o) begin
                if (expHit.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_hit_upd: got set %0d way %0d, expected none at %0t",
                             plru_upd_set_idx_hit_o, plru_upd_way_idx_hit_o, $time);
                end else begin
                    expHitHead = expHit.pop_front();
                    checkOutput("hit_upd", 32'({plru_upd_set_idx_hit_o, plru_upd_way_idx_hit_o}), 32'(expHitHead));
                end
            end
            if (refill_resp_vld_o) begin
                if (expResp.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_refill_resp: got way %0d, expected none at %0t",
                             refill_resp_way_o, $time);
                end else begin
                    expRespHead = expResp.pop_front();
                    checkOutput("refill_resp_way", 32'(refill_resp_way_o), 32'(expRespHead));
                end
            end
        end
    end

    initial begin
        #100000;
        nMismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;

        $display("[TB] reset values");
        applyReset(3);
        settle();
        checkOutput("rst_resp_vld", 32'(refill_resp_vld_o), 32'd0);
        checkOutput("rst_resp_way", 32'(refill_resp_way_o), 32'd0);
        checkOutput("rst_upd_en", 32'(plru_upd_en_hit_o), 32'd0);
        checkOutput("rst_rd_en", 32'(plru_rd_en_refill_o), 32'd0);
        checkOutput("rst_refill_rdy", 32'(refill_rdy_o), 32'd1);
        checkOutput("rst_hit_rdy", 32'(hit_rdy_o), 32'd0);

        $display("[TB] single hit, one-cycle latency");
        applyStimulus(2'b01, 6'd5, 2'd2, 6'd0, 2'd0, 1'b0, 6'd0, 2'd0);
        settle();
        checkOutput("t1_hit_rdy", 32'(hit_rdy_o), 32'b01);
        checkOutput("t1_no_bypass", 32'(plru_upd_en_hit_o), 32'd0);
        expHit.push_back({6'd5, 2'd2});
        tick();
        idle();
        settle();
        checkOutput("t1_upd_en", 32'(plru_upd_en_hit_o), 32'd1);
        checkOutput("t1_upd_set", 32'(plru_upd_set_idx_hit_o), 32'd5);
        checkOutput("t1_upd_way", 32'(plru_upd_way_idx_hit_o), 32'd2);
        tick();
        settle();
        checkOutput("t1_queue_empty", 32'(plru_upd_en_hit_o), 32'd0);

        $display("[TB] refill has priority over a queued hit");
        applyStimulus(2'b01, 6'd7, 2'd1, 6'd0, 2'd0, 1'b0, 6'd0, 2'd0);
        settle();
        checkOutput("t2_hit_rdy", 32'(hit_rdy_o), 32'b01);
        expHit.push_back({6'd7, 2'd1});
        tick();
        applyStimulus(2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 1'b1, 6'd9, 2'd3);
        settle();
        checkOutput("t2_refill_rdy", 32'(refill_rdy_o), 32'd1);
        checkOutput("t2_rd_en", 32'(plru_rd_en_refill_o), 32'd1);
        checkOutput("t2_rd_idx", 32'(plru_rd_idx_refill_o), 32'd9);
        checkOutput("t2_no_hit_strobe", 32'(plru_upd_en_hit_o), 32'd0);
        expResp.push_back(2'd3);
        tick();
        idle();
        settle();
        checkOutput("t2_resp_vld", 32'(refill_resp_vld_o), 32'd1);
        checkOutput("t2_resp_way", 32'(refill_resp_way_o), 32'd3);
        checkOutput("t2_hit_after", 32'(plru_upd_en_hit_o), 32'd1);
        tick();
        settle();
        checkOutput("t2_resp_done", 32'(refill_resp_vld_o), 32'd0);
        checkOutput("t2_way_hold", 32'(refill_resp_way_o), 32'd3);

        $display("[TB] both ports from reset under continuous refill");
        applyReset(2);
        for (int c = 0; c < 7; c++) begin
            applyStimulus(2'b11, 6'(2*c), 2'(c), 6'(2*c+1), ~2'(c), 1'b1, 6'(32+c), 2'(c+1));
            settle();
            checkOutput($sformatf("t3_c%0d_hit_rdy", c), 32'(hit_rdy_o), 32'(T3_HIT_RDY[c]));
            checkOutput($sformatf("t3_c%0d_refill_rdy", c), 32'(refill_rdy_o), 32'(T3_REF_RDY[c]));
            checkOutput($sformatf("t3_c%0d_rd_en", c), 32'(plru_rd_en_refill_o), 32'(T3_REF_RDY[c]));
            checkOutput($sformatf("t3_c%0d_upd_en", c), 32'(plru_upd_en_hit_o), 32'(T3_UPD_EN[c]));
            if (c == 6) checkOutput("t3_c6_resp_vld", 32'(refill_resp_vld_o), 32'd0);
            if (T3_HIT_RDY[c][0]) expHit.push_back({6'(2*c), 2'(c)});
            else if (T3_HIT_RDY[c][1]) expHit.push_back({6'(2*c+1), ~2'(c)});
            if (T3_REF_RDY[c]) expResp.push_back(2'(c+1));
            tick();
        end
        drain();

        $display("[TB] starvation guard with one queued hit");
        applyStimulus(2'b10, 6'd0, 2'd0, 6'd20, 2'd3, 1'b0, 6'd0, 2'd0);
        settle();
        checkOutput("t4_hit_rdy", 32'(hit_rdy_o), 32'b10);
        expHit.push_back({6'd20, 2'd3});
        tick();
        for (int r = 0; r < 6; r++) begin
            applyStimulus(2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 1'b1, 6'(40+r), 2'(r));
            settle();
            checkOutput($sformatf("t4_r%0d_refill_rdy", r), 32'(refill_rdy_o), 32'(T4_REF_RDY[r]));
            checkOutput($sformatf("t4_r%0d_upd_en", r), 32'(plru_upd_en_hit_o), 32'(T4_UPD_EN[r]));
            if (T4_REF_RDY[r]) expResp.push_back(2'(r));
            tick();
        end
        drain();

        $display("[TB] reset with queued hits and a pending response");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b01, 6'(50+c), 2'(c), 6'd0, 2'd0, 1'b1, 6'(60+c), 2'(3-c));
            settle();
            checkOutput($sformatf("t5_c%0d_hit_rdy", c), 32'(hit_rdy_o), 32'b01);
            checkOutput($sformatf("t5_c%0d_refill_rdy", c), 32'(refill_rdy_o), 32'd1);
            expHit.push_back({6'(50+c), 2'(c)});
            expResp.push_back(2'(3-c));
            tick();
        end
        rst = 1'b1;
        expHit.delete();
        expResp.delete();
        applyStimulus(2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 1'b1, 6'd63, 2'd2);
        tick();
        rst = 1'b0;
        idle();
        settle();
        checkOutput("t5_resp_vld", 32'(refill_resp_vld_o), 32'd0);
        checkOutput("t5_resp_way", 32'(refill_resp_way_o), 32'd0);
        checkOutput("t5_upd_en", 32'(plru_upd_en_hit_o), 32'd0);
        checkOutput("t5_rd_en", 32'(plru_rd_en_refill_o), 32'd0);
        checkOutput("t5_refill_rdy", 32'(refill_rdy_o), 32'd1);
        checkOutput("t5_hit_rdy_idle", 32'(hit_rdy_o), 32'd0);
        tick();
        applyStimulus(2'b11, 6'd1, 2'd1, 6'd2, 2'd2, 1'b0, 6'd0, 2'd0);
        settle();
        checkOutput("t5_rr_reset", 32'(hit_rdy_o), 32'b01);
        expHit.push_back({6'd1, 2'd1});
        tick();
        idle();
        repeat (3) tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
